// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word per req/ack handshake
// and holds at most one instruction for decode, with branch/jump redirect support.
//
// state | meaning
// IDLE  | out of reset, no request yet
// FETCH | request outstanding at addr_q
// FULL  | instruction presented to decode, no request
// DROP  | finishing an abandoned request, then fetch target_q
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [5:0]  opcode_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FULL  = 2'd2,
    DROP  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] addr_q;
  logic [31:0] target_q;
  logic [31:0] redirect_pc;
  logic        handshake;

  assign redirect_pc = {redirect_pc_i[31:2], 2'b00};
  assign handshake   = imem_req_o && imem_ack_i;
  assign opcode_o    = instr_o[31:26];
  assign pc_plus4_o  = pc_o + 32'd4;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  state_next = FETCH;
      FETCH: begin
        if (handshake)       state_next = redirect_i ? FETCH : FULL;
        else if (redirect_i) state_next = DROP;
      end
      FULL:  if (redirect_i || !stall_i) state_next = FETCH;
      DROP:  if (handshake) state_next = FETCH;
      default: state_next = IDLE;
    endcase
  end

  // The request is a pure function of state, so an async reset drops it at once.
  always_comb begin
    imem_req_o  = (state == FETCH) || (state == DROP);
    imem_addr_o = addr_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q        <= RESET_PC;
      target_q      <= RESET_PC;
      instr_o       <= 32'h0;
      pc_o          <= RESET_PC;
      instr_valid_o <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (handshake) begin
            if (redirect_i) begin
              addr_q <= redirect_pc;
            end else begin
              instr_o       <= imem_rdata_i;
              pc_o          <= addr_q;
              instr_valid_o <= 1'b1;
              addr_q        <= addr_q + 32'd4;
            end
          end else if (redirect_i) begin
            target_q <= redirect_pc;
          end
        end
        FULL: begin
          if (redirect_i) begin
            instr_valid_o <= 1'b0;
            instr_o       <= 32'h0;
            addr_q        <= redirect_pc;
          end else if (!stall_i) begin
            instr_valid_o <= 1'b0;
          end
        end
        DROP: begin
          // Latest redirect wins, including one arriving with the ack.
          if (handshake)       addr_q   <= redirect_i ? redirect_pc : target_q;
          else if (redirect_i) target_q <= redirect_pc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// memory latency, stalls, redirects and resets against a transaction-level model.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'h0;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [5:0]  opcode_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
    .stall_i(stall_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .instr_valid_o(instr_valid_o), .instr_o(instr_o), .opcode_o(opcode_o),
    .pc_o(pc_o), .pc_plus4_o(pc_plus4_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // memory model
  int          fixed_wait = 0;
  logic        pend = 1'b0;
  logic [31:0] paddr = 32'h0;
  int          rem = 0;
  logic        cur_ack = 1'b0;
  logic        started = 1'b0;

  // reference model: next instruction address, buffered-instruction flag,
  // and whether an abandoned request is still in flight
  logic [31:0] exp_pc = RESET_PC;
  logic        m_valid = 1'b0;
  logic        drop = 1'b0;
  logic        prev_mv = 1'b0, prev_st = 1'b0, prev_rd = 1'b0;
  logic        prev_cap = 1'b0, prev_ack = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0040_0000) return 32'h2008_0005;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic monitor();
    logic        fresh;
    logic [31:0] w;
    m_valid = prev_rd ? 1'b0 : (prev_mv ? prev_st : prev_cap);
    fresh   = (prev_mv && (prev_rd || !prev_st)) || (prev_ack && !prev_cap);
    w       = mem_word(exp_pc);
    check("instr_valid", instr_valid_o, m_valid);
    if (m_valid) begin
      check("pc", pc_o, exp_pc);
      check("instr", instr_o, w);
      check("opcode", opcode_o, w[31:26]);
      check("pc_plus4", pc_plus4_o, exp_pc + 32'd4);
      check("no_req_while_full", imem_req_o, 1'b0);
    end
    if (prev_rd && prev_mv) begin
      check("flush_instr", instr_o, 32'h0);
      check("flush_opcode", opcode_o, 6'h0);
    end
    if (fresh) begin
      check("fresh_req", imem_req_o, 1'b1);
      check("fresh_addr", imem_addr_o, exp_pc);
    end
    if (imem_req_o) check("addr_align", imem_addr_o[1:0], 2'b00);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    monitor();
    if (imem_req_o) begin
      started = 1'b1;
      if (!pend) begin
        pend  = 1'b1;
        paddr = imem_addr_o;
        rem   = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
      end else begin
        check("req_addr_stable", imem_addr_o, paddr);
      end
      imem_ack_i   = (rem == 0);
      imem_rdata_i = (rem == 0) ? mem_word(imem_addr_o) : $urandom;
      if (rem == 0) pend = 1'b0;
      else          rem--;
    end else begin
      if (pend) check("req_held_until_ack", imem_req_o, 1'b1);
      pend         = 1'b0;
      imem_ack_i   = 1'b0;
      imem_rdata_i = $urandom;
    end
    cur_ack = imem_ack_i && imem_req_o;
  endtask

  task automatic drive(input logic st, input logic rd, input logic [31:0] tg);
    logic cap;
    stall_i       = st;
    redirect_i    = rd;
    redirect_pc_i = tg;
    cap = cur_ack && !rd && !drop;
    if (rd)           drop = imem_req_o && !cur_ack;
    else if (cur_ack) drop = 1'b0;
    if (rd)                  exp_pc = {tg[31:2], 2'b00};
    else if (m_valid && !st) exp_pc = exp_pc + 32'd4;
    prev_mv  = m_valid;
    prev_st  = st;
    prev_rd  = rd;
    prev_cap = cap;
    prev_ack = cur_ack;
  endtask

  task automatic run_to_valid(input int max);
    int n = 0;
    while (!instr_valid_o && n < max) begin
      drive(1'b0, 1'b0, 32'h0);
      tick();
      n++;
    end
    check("valid_within_budget", instr_valid_o, 1'b1);
  endtask

  task automatic do_reset(input logic stray);
    #2 reset = 1'b1;
    #1 check("reset_req_async", imem_req_o, 1'b0);
    imem_ack_i    = stray;
    imem_rdata_i  = $urandom;
    stall_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_req", imem_req_o, 1'b0);
    check("reset_valid", instr_valid_o, 1'b0);
    check("reset_instr", instr_o, 32'h0);
    check("reset_pc", pc_o, RESET_PC);
    check("reset_pc_plus4", pc_plus4_o, RESET_PC + 32'd4);
    @(negedge clk) reset = 1'b0;
    pend = 1'b0; drop = 1'b0; started = 1'b0; cur_ack = 1'b0;
    exp_pc = RESET_PC; m_valid = 1'b0;
    prev_mv = 1'b0; prev_st = 1'b0; prev_rd = 1'b0; prev_cap = 1'b0; prev_ack = 1'b0;
  endtask

  initial begin
    int          n;
    int          cnt;
    logic        st;
    logic        rd;
    logic [31:0] tg;

    // zero-wait first fetch
    fixed_wait = 0;
    do_reset(1'b0);
    tick();
    check("t1_req_cycle1", imem_req_o, 1'b1);
    check("t1_addr_cycle1", imem_addr_o, 32'h0040_0000);
    drive(1'b0, 1'b0, 32'h0);
    tick();
    check("t1_valid", instr_valid_o, 1'b1);
    check("t1_opcode", opcode_o, 6'h08);
    check("t1_pc", pc_o, 32'h0040_0000);
    check("t1_pc_plus4", pc_plus4_o, 32'h0040_0004);
    drive(1'b0, 1'b0, 32'h0);

    // 3 wait cycles with stall toggling
    fixed_wait = 3;
    n = 0;
    cnt = 0;
    tick();
    check("t2_next_addr", imem_addr_o, 32'h0040_0004);
    while (!instr_valid_o && n < 10) begin
      if (imem_req_o) cnt++;
      drive(n[0], 1'b0, 32'h0);
      tick();
      n++;
    end
    check("t2_req_cycles", cnt, 4);
    check("t2_captured", instr_valid_o, 1'b1);
    check("t2_pc", pc_o, 32'h0040_0004);

    // stall held for 5 cycles in FULL
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 32'h0);
      tick();
      check("t3_hold_valid", instr_valid_o, 1'b1);
      check("t3_hold_pc", pc_o, 32'h0040_0004);
      check("t3_no_req", imem_req_o, 1'b0);
    end
    drive(1'b0, 1'b0, 32'h0);
    tick();
    check("t3_resume_req", imem_req_o, 1'b1);
    check("t3_resume_addr", imem_addr_o, 32'h0040_0008);

    // redirect in FULL, target low bits ignored
    run_to_valid(20);
    drive(1'b0, 1'b1, 32'h0040_0103);
    tick();
    check("t4_valid", instr_valid_o, 1'b0);
    check("t4_instr", instr_o, 32'h0);
    check("t4_req", imem_req_o, 1'b1);
    check("t4_addr", imem_addr_o, 32'h0040_0100);

    // redirect at wait cycle 1 of a 3-wait fetch
    drive(1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b1, 32'h0040_0200);
    n = 0;
    tick();
    while (imem_addr_o != 32'h0040_0200 && n < 10) begin
      check("t5_no_valid", instr_valid_o, 1'b0);
      drive(1'b0, 1'b0, 32'h0);
      tick();
      n++;
    end
    check("t5_target_addr", imem_addr_o, 32'h0040_0200);

    // second redirect while dropping: latest target wins
    drive(1'b0, 1'b1, 32'h0040_0250);
    tick();
    drive(1'b0, 1'b1, 32'h0040_0300);
    n = 0;
    tick();
    while (imem_addr_o != 32'h0040_0300 && n < 10) begin
      check("t5b_no_valid", instr_valid_o, 1'b0);
      drive(1'b0, 1'b0, 32'h0);
      tick();
      n++;
    end
    check("t5b_target_addr", imem_addr_o, 32'h0040_0300);
    run_to_valid(20);
    check("t5b_pc", pc_o, 32'h0040_0300);

    // wrap-around
    drive(1'b0, 1'b1, 32'hFFFF_FFFC);
    tick();
    run_to_valid(20);
    check("t6_pc", pc_o, 32'hFFFF_FFFC);
    check("t6_pc_plus4", pc_plus4_o, 32'h0000_0000);
    drive(1'b0, 1'b0, 32'h0);
    tick();
    check("t6_wrap_req", imem_req_o, 1'b1);
    check("t6_wrap_addr", imem_addr_o, 32'h0000_0000);

    // reset in the middle of a pending request, stray ack during reset
    do_reset(1'b1);
    tick();
    check("t7_req_after_reset", imem_req_o, 1'b1);
    check("t7_addr_after_reset", imem_addr_o, RESET_PC);
    drive(1'b0, 1'b0, 32'h0);

    // random latency, stalls, redirects and occasional resets
    fixed_wait = -1;
    for (int c = 0; c < 3000; c++) begin
      tick();
      st = ($urandom_range(0, 2) == 0);
      rd = started && ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 2))
        0:       tg = $urandom;
        1:       tg = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: tg = 32'h0040_0000 + 32'($urandom_range(0, 255));
      endcase
      drive(st, rd, tg);
      if (c % 997 == 996) do_reset(1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
